multdiv_iter: RTL and testbench

- Parametrised iterative signed multiply/divide unit for the 5-stage pipeline's execute stage. It extends the single-cycle ALU path with a multi-cycle mode.
- The pipeline issues an operation and stalls D/X while `busy` is high. It consumes `result`/`exception` on the single-cycle `result_ready` pulse. The overflow path writes $rstatus exactly as for ALU overflow.
- Multiply is radix-2 Booth. Divide is restoring on magnitudes with sign fix-up.

---
 rtl/proc_pkg.sv | 18 +
 rtl/booth_step.sv | 33 +++
 rtl/multdiv_iter.sv | 163 ++++++++++++++++
 tb/tb_multdiv_iter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions used by the execute-stage multiply/divide unit
// and by write-back.
//   md_state_e      : multiply/divide sequencer state encoding
//   RSTATUS_MUL_OVF : $rstatus code written on multiply overflow
//   RSTATUS_DIV_OVF : $rstatus code written on divide overflow / divide-by-zero
package proc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  localparam logic [3:0] RSTATUS_MUL_OVF = 4'd4;
  localparam logic [3:0] RSTATUS_DIV_OVF = 4'd5;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of the multiplicand into the
// upper half of the accumulator, followed by an arithmetic shift right by one.
// Ports:
//   i_acc   : {upper W bits, multiplier W bits, Booth q(-1) bit}
//   i_mcand : signed multiplicand
//   o_acc   : accumulator after this step
module booth_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH:0] i_acc,
  input  logic [WIDTH-1:0] i_mcand,
  output logic [2*WIDTH:0] o_acc
);

  logic [WIDTH:0] w_hi;
  logic [WIDTH:0] w_m;
  logic [WIDTH:0] w_sum;

  // The add/sub is done one bit wider than the upper half so that
  // subtracting MIN_INT cannot wrap; the shift then drops that extra bit
  // back out, keeping the true sign in the stored W bits.
  always_comb begin
    w_hi = {i_acc[2*WIDTH], i_acc[2*WIDTH:WIDTH+1]};
    w_m  = {i_mcand[WIDTH-1], i_mcand};
    unique case (i_acc[1:0])
      2'b01:   w_sum = w_hi + w_m;
      2'b10:   w_sum = w_hi - w_m;
      default: w_sum = w_hi;
    endcase
    o_acc = {w_sum, i_acc[WIDTH:1]};
  end

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed multiply/divide unit for the execute stage. One result bit
// per clock; the pipeline stalls on busy and consumes result/exception on the
// single-cycle result_ready pulse.
// Ports:
//   clock, reset(active-low, synchronous), flush(abort in-flight op)
//   ctrl_MULT / ctrl_DIV          : start strobes (MULT wins if both)
//   data_operandA / data_operandB : operands, sampled only on the start edge
//   result, exception             : registered outcome, held until next completion
//   result_ready                  : one-cycle completion pulse
//   busy                          : high while iterating (stall request)
module multdiv_iter
  import proc_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             result_ready,
  output logic             busy
);

  md_state_e r_state;
  md_state_e w_next;

  logic [CNT_W-1:0]   r_count;
  logic [2*WIDTH:0]   r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvsr;
  logic               r_neg;
  logic               r_dz;
  logic [WIDTH-1:0]   r_result;
  logic               r_exc;

  logic               w_start;
  logic               w_last;
  logic [2*WIDTH:0]   w_acc_n;
  logic               w_mul_ovf;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_n;
  logic [WIDTH-1:0]   w_quo_n;
  logic [WIDTH-1:0]   w_quo_signed;

  assign w_start = ctrl_MULT | ctrl_DIV;
  assign w_last  = (r_count == CNT_W'(WIDTH - 1));

  booth_step #(.WIDTH(WIDTH)) u_booth (
    .i_acc   (r_acc),
    .i_mcand (r_mcand),
    .o_acc   (w_acc_n)
  );

  // Product lives in w_acc_n[2W:1]; overflow when the upper half is not the
  // sign extension of the low half.
  assign w_mul_ovf = (w_acc_n[2*WIDTH:WIDTH+1] != {WIDTH{w_acc_n[WIDTH]}});

  assign w_absA = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_absB = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  // Restoring divide step on magnitudes. The partial remainder is always
  // below the divisor, so the W-bit difference is exact whenever w_ge.
  always_comb begin
    w_shift      = {r_rem, r_quo[WIDTH-1]};
    w_ge         = (w_shift >= {1'b0, r_dvsr});
    w_rem_n      = w_ge ? (w_shift[WIDTH-1:0] - r_dvsr) : w_shift[WIDTH-1:0];
    w_quo_n      = {r_quo[WIDTH-2:0], w_ge};
    w_quo_signed = r_neg ? -w_quo_n : w_quo_n;
  end

  // Next state: iteration progress, then flush abort, then start (highest).
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = IDLE;
      MUL:     if (w_last) w_next = DONE;
      DIV:     if (r_dz || w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_start) begin
      w_next = ctrl_MULT ? MUL : DIV;
    end else if (flush) begin
      w_next = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_neg    <= 1'b0;
      r_dz     <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
    end else if (w_start) begin
      r_count <= '0;
      r_acc   <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
      r_mcand <= data_operandA;
      r_rem   <= '0;
      r_quo   <= w_absA;
      r_dvsr  <= w_absB;
      r_neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      r_dz    <= (data_operandB == '0);
    end else if (!flush) begin
      unique case (r_state)
        MUL: begin
          r_acc   <= w_acc_n;
          r_count <= r_count + CNT_W'(1);
          if (w_last) begin
            r_result <= w_acc_n[WIDTH:1];
            r_exc    <= w_mul_ovf;
          end
        end
        DIV: begin
          if (r_dz) begin
            r_result <= '0;
            r_exc    <= 1'b1;
          end else begin
            r_rem   <= w_rem_n;
            r_quo   <= w_quo_n;
            r_count <= r_count + CNT_W'(1);
            if (w_last) begin
              // Only MIN_INT / -1 yields a positive quotient with the top bit set.
              r_result <= w_quo_signed;
              r_exc    <= ~r_neg & w_quo_n[WIDTH-1];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign result       = r_result;
  assign exception    = r_exc;
  assign busy         = (r_state == MUL) || (r_state == DIV);
  assign result_ready = (r_state == DONE);

endmodule

// File: tb/tb_multdiv_iter.sv
module tb_multdiv_iter;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic         ctrl_MULT = 1'b0;
  logic         ctrl_DIV = 1'b0;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic [W-1:0] result;
  logic         exception;
  logic         result_ready;
  logic         busy;

  multdiv_iter #(.WIDTH(W)) dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .result        (result),
    .exception     (exception),
    .result_ready  (result_ready),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         exc;
    int unsigned  due;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input bit mul, input logic [W-1:0] av,
                                 input logic [W-1:0] bv, input int unsigned due);
    exp_t   e;
    int     sa;
    int     sbv;
    longint p;
    sa  = av;
    sbv = bv;
    e.due = due;
    if (mul) begin
      p     = longint'(sa) * longint'(sbv);
      e.res = p[31:0];
      e.exc = (p[63:32] != {32{p[31]}});
    end else if (bv == '0) begin
      e.res = '0;
      e.exc = 1'b1;
    end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
      e.res = 32'h8000_0000;
      e.exc = 1'b1;
    end else begin
      e.res = sa / sbv;
      e.exc = 1'b0;
    end
    return e;
  endfunction

  // Completion monitor: every ready pulse must match the oldest expected entry.
  always @(negedge clock) begin
    if (result_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", {31'b0, result_ready}, '0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("exception", {31'b0, exception}, {31'b0, e.exc});
        chk("ready_cycle", cyc, e.due);
      end
    end
  end

  // Called at a negedge; returns at the negedge of cycle 1 after the start edge.
  task automatic issue(input bit mul, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input bit track);
    int unsigned lat;
    lat = (!mul && bv == '0) ? 1 : W;
    ctrl_MULT     = mul;
    ctrl_DIV      = ~mul;
    data_operandA = av;
    data_operandB = bv;
    if (track) sb.push_back(model(mul, av, bv, cyc + 1 + lat));
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 80; i++) begin
      if (sb.size() == 0) break;
      @(negedge clock);
    end
    chk("drain_timeout", sb.size(), '0);
    @(negedge clock);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_result", result, '0);
    chk("rst_exception", {31'b0, exception}, '0);
    chk("rst_ready", {31'b0, result_ready}, '0);
    chk("rst_busy", {31'b0, busy}, '0);

    issue(1'b1, 32'd7, -32'sd3, 1'b1);
    chk("mul_busy_c1", {31'b0, busy}, 32'd1);
    repeat (31) @(negedge clock);
    chk("mul_busy_c32", {31'b0, busy}, 32'd1);
    chk("mul_noready_c32", {31'b0, result_ready}, '0);
    @(negedge clock);
    chk("mul_busy_c33", {31'b0, busy}, '0);
    wait_drain();

    issue(1'b1, 32'h4000_0000, 32'd4, 1'b1);
    wait_drain();
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_drain();
    issue(1'b0, -32'sd22, 32'd5, 1'b1);
    wait_drain();
    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_drain();

    issue(1'b0, 32'd9, 32'd0, 1'b1);
    chk("div0_busy_c1", {31'b0, busy}, 32'd1);
    @(negedge clock);
    chk("div0_busy_c2", {31'b0, busy}, '0);
    wait_drain();

    // Restart: MULT aborted by a DIV issued at cycle 10.
    issue(1'b1, 32'd3, 32'd4, 1'b0);
    repeat (8) @(negedge clock);
    issue(1'b0, 32'd100, 32'd7, 1'b1);
    wait_drain();

    // Flush aborts a divide; result holds the last completion (14).
    issue(1'b0, 32'd50, 32'd3, 1'b0);
    repeat (4) @(negedge clock);
    chk("flush_busy_c5", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    chk("flush_busy_c6", {31'b0, busy}, '0);
    repeat (40) @(negedge clock);
    chk("flush_hold_result", result, 32'd14);
    chk("flush_hold_exc", {31'b0, exception}, '0);

    // Flush together with a start: the start proceeds.
    flush = 1'b1;
    issue(1'b1, -32'sd5, -32'sd6, 1'b1);
    flush = 1'b0;
    wait_drain();

    // Reset mid-divide zeroes everything and produces no ready.
    issue(1'b0, 32'd1000, 32'd3, 1'b0);
    repeat (11) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rstmid_busy", {31'b0, busy}, '0);
    chk("rstmid_result", result, '0);
    chk("rstmid_exc", {31'b0, exception}, '0);
    chk("rstmid_ready", {31'b0, result_ready}, '0);
    reset = 1'b1;
    repeat (40) @(negedge clock);

    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = $urandom;
      rb = (i == 5) ? 32'd0 : (i[0] ? W'($urandom_range(0, 255)) - 32'd128 : $urandom);
      issue(i[0], ra, rb, 1'b1);
      wait_drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
